// File: rtl/player_anim_ctrl.sv
// Per-player animation sequencer: tracks IDLE/RUN/JUMP/AIR motion state and
// steps the sprite frame on qualified vblank ticks, driving the sprite-address stage.
module player_anim_ctrl #(
   parameter int unsigned FRAME_SIZE      = 1080,
   parameter int unsigned IDLE_BASE       = 0,
   parameter int unsigned RUN_BASE        = 1080,
   parameter int unsigned RUN_FRAMES      = 6,
   parameter int unsigned JUMP_BASE       = 7560,
   parameter int unsigned JUMP_FRAMES     = 4,
   parameter int unsigned FRAMES_PER_STEP = 6,
   parameter int unsigned JUMP_TIMEOUT    = 8
) (
   input  logic        frame_Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        paused,
   input  logic        moveLeft,
   input  logic        moveRight,
   input  logic        jumpReq,
   input  logic        onGround,
   output logic [31:0] animationOffset,
   output logic        playerDirection,
   output logic [1:0]  animState,
   output logic [2:0]  frameIdx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_JUMP = 2'd2,
      ST_AIR  = 2'd3
   } anim_state_t;

   localparam int STEP_W = $clog2(FRAMES_PER_STEP + 1);
   localparam int TMR_W  = $clog2(JUMP_TIMEOUT + 1);

   anim_state_t        r_state;
   logic [2:0]         r_frame_idx;
   logic [STEP_W-1:0]  r_step_cnt;
   logic [TMR_W-1:0]   r_gnd_tmr;
   logic [31:0]        r_offset;
   logic               r_dir;

   anim_state_t        w_next_state;
   logic [2:0]         w_next_frame;
   logic [STEP_W-1:0]  w_next_step;
   logic [TMR_W-1:0]   w_next_tmr;
   logic [31:0]        w_next_offset;
   logic               w_next_dir;
   logic               w_single;
   logic               w_tick;

   // A tick that arrives while paused is dropped, not deferred.
   assign w_tick   = frame_tick & ~paused;
   assign w_single = moveLeft ^ moveRight;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_next_state  = r_state;
      w_next_frame  = r_frame_idx;
      w_next_step   = r_step_cnt;
      w_next_tmr    = r_gnd_tmr;
      w_next_dir    = r_dir;
      w_next_offset = 32'(IDLE_BASE);

      if (moveRight && !moveLeft)      w_next_dir = 1'b0;
      else if (moveLeft && !moveRight) w_next_dir = 1'b1;

      case (r_state)
         ST_IDLE: begin
            if (!onGround)    w_next_state = ST_AIR;
            else if (jumpReq) w_next_state = ST_JUMP;
            else if (w_single) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (!onGround)     w_next_state = ST_AIR;
            else if (jumpReq)  w_next_state = ST_JUMP;
            else if (!w_single) w_next_state = ST_IDLE;
         end
         ST_JUMP: begin
            if (!onGround)                                   w_next_state = ST_AIR;
            else if (r_gnd_tmr == TMR_W'(JUMP_TIMEOUT - 1)) w_next_state = ST_IDLE;
            else                                             w_next_tmr   = r_gnd_tmr + TMR_W'(1);
         end
         ST_AIR: begin
            if (onGround) w_next_state = w_single ? ST_RUN : ST_IDLE;
         end
      endcase

      if (w_next_state != r_state) begin
         w_next_frame = '0;
         w_next_step  = '0;
         w_next_tmr   = '0;
      end else if (r_state == ST_IDLE) begin
         w_next_frame = '0;
         w_next_step  = '0;
      end else if (r_step_cnt == STEP_W'(FRAMES_PER_STEP - 1)) begin
         w_next_step = '0;
         if (r_state == ST_RUN)
            w_next_frame = (r_frame_idx == 3'(RUN_FRAMES - 1))  ? 3'd0 : r_frame_idx + 3'd1;
         else
            w_next_frame = (r_frame_idx == 3'(JUMP_FRAMES - 1)) ? 3'd0 : r_frame_idx + 3'd1;
      end else begin
         w_next_step = r_step_cnt + STEP_W'(1);
      end

      // Offset derives from the next-state values so it is registered in step with them.
      case (w_next_state)
         ST_IDLE: w_next_offset = 32'(IDLE_BASE);
         ST_RUN:  w_next_offset = 32'(RUN_BASE)  + 32'(w_next_frame) * 32'(FRAME_SIZE);
         default: w_next_offset = 32'(JUMP_BASE) + 32'(w_next_frame) * 32'(FRAME_SIZE);
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge frame_Clk or negedge Reset) begin
      if (!Reset) begin
         r_state     <= ST_IDLE;
         r_frame_idx <= '0;
         r_step_cnt  <= '0;
         r_gnd_tmr   <= '0;
         r_offset    <= 32'(IDLE_BASE);
         r_dir       <= 1'b0;
      end else if (w_tick) begin
         r_state     <= w_next_state;
         r_frame_idx <= w_next_frame;
         r_step_cnt  <= w_next_step;
         r_gnd_tmr   <= w_next_tmr;
         r_offset    <= w_next_offset;
         r_dir       <= w_next_dir;
      end
   end

   assign animState       = r_state;
   assign frameIdx        = r_frame_idx;
   assign animationOffset = r_offset;
   assign playerDirection = r_dir;

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Bench for player_anim_ctrl: a tick-count model of the animation rules is compared
// every cycle, with literal checkpoints along the directed scenarios.
module tb_player_anim_ctrl;

   localparam int FS   = 1080;
   localparam int FPS  = 6;
   localparam int TMO  = 8;

   logic        frame_Clk = 1'b0;
   logic        Reset     = 1'b0;
   logic        frame_tick = 1'b0;
   logic        paused    = 1'b0;
   logic        moveLeft  = 1'b0;
   logic        moveRight = 1'b0;
   logic        jumpReq   = 1'b0;
   logic        onGround  = 1'b1;
   logic [31:0] animationOffset;
   logic        playerDirection;
   logic [1:0]  animState;
   logic [2:0]  frameIdx;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   player_anim_ctrl dut (
      .frame_Clk       (frame_Clk),
      .Reset           (Reset),
      .frame_tick      (frame_tick),
      .paused          (paused),
      .moveLeft        (moveLeft),
      .moveRight       (moveRight),
      .jumpReq         (jumpReq),
      .onGround        (onGround),
      .animationOffset (animationOffset),
      .playerDirection (playerDirection),
      .animState       (animState),
      .frameIdx        (frameIdx)
   );

   always #5 frame_Clk = ~frame_Clk;

   // Model: state plus number of qualified ticks spent in it since entry.
   typedef struct packed {
      int st;
      int n;
      bit dir;
   } model_t;

   model_t m;

   function automatic model_t model_next(model_t cur, bit l, bit r, bit j, bit g);
      model_t nx = cur;
      bit single = l ^ r;
      int ns = cur.st;
      if (r && !l) nx.dir = 1'b0;
      else if (l && !r) nx.dir = 1'b1;
      case (cur.st)
         0: ns = !g ? 3 : j ? 2 : single ? 1 : 0;
         1: ns = !g ? 3 : j ? 2 : !single ? 0 : 1;
         2: ns = !g ? 3 : (cur.n == TMO - 1) ? 0 : 2;
         default: ns = g ? (single ? 1 : 0) : 3;
      endcase
      if (ns != cur.st) begin
         nx.st = ns;
         nx.n  = 0;
      end else if (ns != 0) begin
         nx.n = cur.n + 1;
      end
      return nx;
   endfunction

   function automatic int exp_frame(model_t x);
      if (x.st == 0) return 0;
      return (x.n / FPS) % ((x.st == 1) ? 6 : 4);
   endfunction

   function automatic int exp_offset(model_t x);
      case (x.st)
         0: return 0;
         1: return 1080 + exp_frame(x) * FS;
         default: return 7560 + exp_frame(x) * FS;
      endcase
   endfunction

   always @(posedge frame_Clk or negedge Reset) begin
      if (!Reset) m <= '{st: 0, n: 0, dir: 1'b0};
      else if (frame_tick && !paused)
         m <= model_next(m, moveLeft, moveRight, jumpReq, onGround);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge frame_Clk) begin
      if (cmp_en) begin
         check("model_state",  animState,       m.st);
         check("model_frame",  frameIdx,        exp_frame(m));
         check("model_offset", animationOffset, exp_offset(m));
         check("model_dir",    playerDirection, m.dir);
      end
   end

   task automatic check_out(input string name, input int st, input int fi, input int off, input int dir);
      check({name, "_state"},  animState,       st);
      check({name, "_frame"},  frameIdx,        fi);
      check({name, "_offset"}, animationOffset, off);
      check({name, "_dir"},    playerDirection, dir);
   endtask

   // One qualified (or paused) tick, preceded by a few cycles of input glitches.
   task automatic do_tick(input bit l, input bit r, input bit j, input bit g, input bit p = 1'b0);
      int gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
         @(negedge frame_Clk);
         frame_tick = 1'b0;
         moveLeft   = 1'($urandom);
         moveRight  = 1'($urandom);
         jumpReq    = 1'($urandom);
         onGround   = 1'($urandom);
         paused     = 1'($urandom);
      end
      @(negedge frame_Clk);
      moveLeft   = l;
      moveRight  = r;
      jumpReq    = j;
      onGround   = g;
      paused     = p;
      frame_tick = 1'b1;
      @(negedge frame_Clk);
      frame_tick = 1'b0;
      #1;
   endtask

   initial begin
      repeat (2) @(negedge frame_Clk);
      #2;
      check_out("reset", 0, 0, 0, 0);
      @(negedge frame_Clk);
      Reset  = 1'b1;
      cmp_en = 1'b1;

      // Run right from IDLE through a full strip wrap.
      for (int t = 1; t <= 37; t++) begin
         do_tick(1'b0, 1'b1, 1'b0, 1'b1);
         if (t == 1)  check_out("run_t1",  1, 0, 1080, 0);
         if (t == 7)  check_out("run_t7",  1, 1, 2160, 0);
         if (t == 31) check_out("run_t31", 1, 5, 6480, 0);
         if (t == 37) check_out("run_t37", 1, 0, 1080, 0);
      end
      for (int t = 38; t <= 49; t++) do_tick(1'b0, 1'b1, 1'b0, 1'b1);
      check_out("run_f2", 1, 2, 3240, 0);

      // Direction flip keeps the frame sequence running.
      do_tick(1'b1, 1'b0, 1'b0, 1'b1);
      check_out("dir_flip", 1, 2, 3240, 1);
      for (int t = 51; t <= 55; t++) do_tick(1'b1, 1'b0, 1'b0, 1'b1);
      check_out("run_f3", 1, 3, 4320, 1);

      // Asynchronous reset mid-RUN, away from any clock edge.
      @(negedge frame_Clk);
      #2;
      Reset = 1'b0;
      #1;
      check_out("async_rst", 0, 0, 0, 0);
      @(negedge frame_Clk);
      Reset = 1'b1;
      for (int t = 0; t < 10; t++) do_tick(1'b0, 1'b0, 1'b0, 1'b1);
      check_out("idle_10", 0, 0, 0, 0);

      // Jump, airborne strip wrap, land into RUN.
      do_tick(1'b1, 1'b0, 1'b0, 1'b1);
      do_tick(1'b1, 1'b0, 1'b1, 1'b1);
      check_out("jump", 2, 0, 7560, 1);
      do_tick(1'b1, 1'b0, 1'b0, 1'b0);
      check_out("air", 3, 0, 7560, 1);
      for (int t = 1; t <= 24; t++) begin
         do_tick(1'b1, 1'b0, 1'b0, 1'b0);
         if (t == 18) check_out("air_f3", 3, 3, 10800, 1);
         if (t == 24) check_out("air_wrap", 3, 0, 7560, 1);
      end
      do_tick(1'b1, 1'b0, 1'b0, 1'b1);
      check_out("land", 1, 0, 1080, 1);

      // Grounded jump times out.
      for (int t = 1; t <= 9; t++) begin
         do_tick(1'b0, 1'b0, 1'b1, 1'b1);
         if (t <= 8) check("jump_hold_state", animState, 2);
         else        check_out("jump_abort", 0, 0, 0, 1);
      end

      // Pause freezes everything; first unpaused tick advances by one step.
      do_tick(1'b0, 1'b1, 1'b0, 1'b1);
      for (int t = 0; t < 4; t++) do_tick(1'b0, 1'b1, 1'b0, 1'b1);
      for (int t = 0; t < 20; t++) begin
         do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         check_out("paused", 1, 0, 1080, 0);
      end
      do_tick(1'b0, 1'b1, 1'b0, 1'b1);
      check_out("unpause1", 1, 0, 1080, 0);
      do_tick(1'b0, 1'b1, 1'b0, 1'b1);
      check_out("unpause2", 1, 1, 2160, 0);

      // Randomized traffic against the model.
      for (int t = 0; t < 1500; t++) begin
         do_tick(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
      end

      @(negedge frame_Clk);
      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
